regfile_writeback: RTL

//  Write-side front end of the register file. Two producers hand results over

---
 rtl/regfile_writeback.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrated in-order write queue in front of the register file, with forwarding lookups
module regfile_writeback #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [WIDTH-1:0]         mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [WIDTH-1:0]         alu_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_w_addr,
  output logic [WIDTH-1:0]         rf_in,
  input  logic [ADDR_W-1:0]        look_addr_1,
  output logic                     fwd_hit_1,
  output logic [WIDTH-1:0]         fwd_data_1,
  input  logic [ADDR_W-1:0]        look_addr_2,
  output logic                     fwd_hit_2,
  output logic [WIDTH-1:0]         fwd_data_2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] rd_q [DEPTH];
  logic [ADDR_W-1:0] rd_d [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [WIDTH-1:0]  data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, keep, pop;
  logic [ADDR_W-1:0] in_rd;
  logic [WIDTH-1:0]  in_data;
  // Arbitration (load wins), drain of the head entry, and queue bookkeeping
  always_comb begin
    mem_ready = count_q < CW'(DEPTH);
    alu_ready = mem_ready && !mem_valid;
    in_rd     = mem_valid ? mem_rd : alu_rd;
    in_data   = mem_valid ? mem_data : alu_data;
    push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    keep      = push && in_rd != '0;
    pop       = count_q != '0;
    rf_we     = pop && !rst;
    rf_w_addr = rd_q[head_q];
    rf_in     = data_q[head_q];
    count     = count_q;
    rd_d      = rd_q;
    data_d    = data_q;
    if (keep) begin
      rd_d[tail_q]   = in_rd;
      data_d[tail_q] = in_data;
    end
    tail_d  = keep ? tail_q + 1'b1 : tail_q;
    head_d  = pop ? head_q + 1'b1 : head_q;
    count_d = count_q + CW'(keep) - CW'(pop);
  end
  // Forwarding: scan oldest to youngest so the youngest match overrides
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && CW'(i) < count_q && look_addr_1 != '0 && rd_q[head_q + PW'(i)] == look_addr_1) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = data_q[head_q + PW'(i)];
      end
      if (!rst && CW'(i) < count_q && look_addr_2 != '0 && rd_q[head_q + PW'(i)] == look_addr_2) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = data_q[head_q + PW'(i)];
      end
    end
  end
  // Pointer and occupancy registers; reset discards every queued entry
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // Entry storage needs no reset: validity comes from the pointers and count
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end
endmodule
